// File: rtl/inst_mem_pkg.sv
// Shared constants and state encoding for the instruction memory and its RAM.
package inst_mem_pkg;

    localparam int unsigned IMEM_DEPTH = 1024;
    localparam int unsigned IMEM_AW    = 10;
    localparam logic [31:0] IMEM_NOP   = 32'h00000013;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD_LO = 2'd1,
        LOAD_HI = 2'd2
    } imem_state_e;

endpackage

// File: rtl/inst_mem_ram.sv
// Single-port synchronous RAM, DEPTH x 64, one-cycle registered read.
module imem_ram
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [IMEM_AW-1:0] addr_i,
    input  logic [63:0]        wdata_i,
    output logic [63:0]        rdata_o
);

    logic [63:0] mem [DEPTH];
    logic [63:0] rdata_q;

    // Storage is intentionally never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem.sv
// Instruction fetch memory with a streaming program loader that packs 32-bit
// words into 64-bit fetch lines.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH,
    parameter logic [31:0] NOP   = IMEM_NOP
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [9:0]  addr_i,
    output logic [63:0] data_o,
    output logic        data_valid_o,
    input  logic        load_start_i,
    input  logic        load_valid_i,
    input  logic [31:0] load_data_i,
    input  logic        load_last_i,
    output logic        load_ready_o,
    output logic        load_done_o
);

    imem_state_e        state_q, state_d;
    logic [IMEM_AW-1:0] ptr_q, ptr_d;
    logic [31:0]        low_q, low_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic               accept;
    logic               ptr_at_end;
    logic               ram_we;
    logic               ram_re;
    logic [IMEM_AW-1:0] ram_addr;
    logic [63:0]        ram_wdata;
    logic [63:0]        ram_rdata;

    assign load_ready_o = (state_q != RUN) && !load_start_i;
    assign accept       = load_valid_i && load_ready_o;
    assign ptr_at_end   = (ptr_q == IMEM_AW'(DEPTH - 1));
    assign ram_re       = (state_q == RUN);
    assign ram_addr     = ram_re ? addr_i : ptr_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        low_d     = low_q;
        done_d    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = {NOP, load_data_i};
        valid_d   = ram_re;

        if (load_start_i) begin
            state_d = LOAD_LO;
            ptr_d   = '0;
        end else begin
            case (state_q)
                LOAD_LO: begin
                    if (accept) begin
                        if (load_last_i) begin
                            ram_we  = 1'b1;
                            done_d  = 1'b1;
                            state_d = RUN;
                        end else begin
                            low_d   = load_data_i;
                            state_d = LOAD_HI;
                        end
                    end
                end
                LOAD_HI: begin
                    if (accept) begin
                        ram_we    = 1'b1;
                        ram_wdata = {load_data_i, low_q};
                        ptr_d     = ptr_at_end ? '0 : ptr_q + 1'b1;
                        // Filling the last line ends the load even without load_last_i.
                        if (load_last_i || ptr_at_end) begin
                            done_d  = 1'b1;
                            state_d = RUN;
                        end else begin
                            state_d = LOAD_LO;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= RUN;
            ptr_q   <= '0;
            low_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            low_q   <= low_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    imem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clock_i),
        .we_i    (ram_we && !reset_i),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign data_o       = valid_q ? ram_rdata : {NOP, NOP};
    assign data_valid_o = valid_q;
    assign load_done_o  = done_q;

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: directed load/fetch corner cases plus
// randomized program loads checked against a line-packing reference model.
module tb_inst_mem;

    localparam logic [31:0] NOPW = 32'h00000013;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [9:0]  addr_i;
    logic [63:0] data_o;
    logic        data_valid_o;
    logic        load_start_i;
    logic        load_valid_i;
    logic [31:0] load_data_i;
    logic        load_last_i;
    logic        load_ready_o;
    logic        load_done_o;

    inst_mem #(
        .DEPTH (1024),
        .NOP   (32'h00000013)
    ) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .addr_i       (addr_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .load_start_i (load_start_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_last_i  (load_last_i),
        .load_ready_o (load_ready_o),
        .load_done_o  (load_done_o)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clock_i) begin
        if (load_done_o === 1'b1) done_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    logic [63:0] ref_mem [1024];
    bit          known   [1024];

    typedef struct packed {
        logic [9:0]  addr;
        logic [63:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [6];

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic blank_chk();
        chk("blank_valid", 64'(data_valid_o), 64'd0);
        chk("blank_data", data_o, {NOPW, NOPW});
    endtask

    // Reference: word pairs become lines from 0 upward (wrapping at 1024);
    // a finished odd-length program pads its final line with NOP.
    function automatic void model_load(input logic [31:0] w[$], input bit finished);
        int n = w.size();
        for (int i = 0; i + 1 < n; i += 2) begin
            ref_mem[(i / 2) % 1024] = {w[i + 1], w[i]};
            known[(i / 2) % 1024]   = 1'b1;
        end
        if (finished && (n % 2 == 1)) begin
            ref_mem[(n / 2) % 1024] = {NOPW, w[n - 1]};
            known[(n / 2) % 1024]   = 1'b1;
        end
    endfunction

    task automatic start_load();
        load_start_i = 1'b1;
        load_valid_i = 1'b0;
        step();
        load_start_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            load_valid_i = 1'b0;
            addr_i = 10'($urandom);
            step();
            blank_chk();
        end
        load_valid_i = 1'b1;
        load_data_i  = w;
        load_last_i  = last;
        addr_i       = 10'($urandom);
        #0;
        n = 0;
        while (!load_ready_o && n < 20) begin
            step();
            n++;
        end
        chk("load_ready", 64'(load_ready_o), 64'd1);
        step();
        blank_chk();
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
    endtask

    task automatic run_load(input logic [31:0] w[$], input bit finished, input int maxgap);
        start_load();
        for (int i = 0; i < w.size(); i++) begin
            send_word(w[i], finished && (i == w.size() - 1), $urandom_range(maxgap, 0));
        end
    endtask

    // Current cycle is the one after the completing write.
    task automatic finish_load(input int d0);
        chk("done_pulse", 64'(load_done_o), 64'd1);
        chk("done_valid_low", 64'(data_valid_o), 64'd0);
        addr_i = 10'd0;
        step();
        chk("done_cleared", 64'(load_done_o), 64'd0);
        chk("valid_returns", 64'(data_valid_o), 64'd1);
        chk("valid_line0", data_o, ref_mem[0]);
        chk("done_count", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic read_line(input logic [9:0] a, input string nm, input logic [63:0] exp);
        addr_i = a;
        step();
        chk({nm, "_valid"}, 64'(data_valid_o), 64'd1);
        chk(nm, data_o, exp);
    endtask

    task automatic read_known(input int cnt);
        int a;
        for (int r = 0; r < cnt; r++) begin
            a = $urandom_range(1023, 0);
            while (!known[a]) a = (a + 1) % 1024;
            read_line(10'(a), "rand_read", ref_mem[a]);
        end
    endtask

    initial begin
        logic [31:0] prog[$];
        logic [31:0] part[$];
        int d0;
        int n;
        int k;

        vecs[0] = '{addr: 10'd5, exp: 64'hAAAA0002_BBBB0001};
        vecs[1] = '{addr: 10'd0, exp: 64'h10000001_10000000};
        vecs[2] = '{addr: 10'd1, exp: 64'h10000003_10000002};
        vecs[3] = '{addr: 10'd2, exp: 64'h10000005_10000004};
        vecs[4] = '{addr: 10'd3, exp: 64'h10000007_10000006};
        vecs[5] = '{addr: 10'd4, exp: 64'h10000009_10000008};
        for (int i = 0; i < 1024; i++) known[i] = 1'b0;

        reset_i = 1'b1;
        addr_i = '0;
        load_start_i = 1'b0;
        load_valid_i = 1'b0;
        load_data_i = '0;
        load_last_i = 1'b0;
        step();
        step();
        chk("reset_data", data_o, {NOPW, NOPW});
        chk("reset_valid", 64'(data_valid_o), 64'd0);
        chk("reset_done", 64'(load_done_o), 64'd0);
        chk("reset_ready", 64'(load_ready_o), 64'd0);
        chk("reset_ptr", 64'(dut.ptr_q), 64'd0);
        reset_i = 1'b0;
        chk("valid_c1", 64'(data_valid_o), 64'd0);
        step();
        chk("valid_c2", 64'(data_valid_o), 64'd1);

        // Six-line program placing AAAA0002_BBBB0001 at line 5.
        prog = {};
        for (int i = 0; i < 10; i++) prog.push_back(32'h10000000 + 32'(i));
        prog.push_back(32'hBBBB0001);
        prog.push_back(32'hAAAA0002);
        d0 = done_cnt;
        run_load(prog, 1'b1, 0);
        model_load(prog, 1'b1);
        finish_load(d0);
        for (int i = 0; i < 6; i++) read_line(vecs[i].addr, "table_read", vecs[i].exp);

        // Odd-length load.
        prog = '{32'd1, 32'd2, 32'd3};
        d0 = done_cnt;
        run_load(prog, 1'b1, 2);
        model_load(prog, 1'b1);
        finish_load(d0);
        read_line(10'd0, "odd_line0", 64'h00000002_00000001);
        read_line(10'd1, "odd_line1", {NOPW, 32'h00000003});
        read_line(10'd5, "odd_untouched5", 64'hAAAA0002_BBBB0001);

        // Start colliding with valid while in RUN.
        load_start_i = 1'b1;
        load_valid_i = 1'b1;
        load_data_i  = 32'd9;
        #0;
        chk("collide_run_ready", 64'(load_ready_o), 64'd0);
        step();
        load_start_i = 1'b0;
        load_valid_i = 1'b0;
        chk("collide_run_ptr", 64'(dut.ptr_q), 64'd0);
        d0 = done_cnt;
        send_word(32'h55, 1'b0, 0);
        send_word(32'h66, 1'b1, 0);
        prog = '{32'h55, 32'h66};
        model_load(prog, 1'b1);
        finish_load(d0);
        read_line(10'd0, "collide_run_line0", 64'h00000066_00000055);

        // Start colliding with valid while a low word is pending.
        start_load();
        send_word(32'hA1, 1'b0, 0);
        load_start_i = 1'b1;
        load_valid_i = 1'b1;
        load_data_i  = 32'hB2;
        #0;
        chk("collide_hi_ready", 64'(load_ready_o), 64'd0);
        step();
        load_start_i = 1'b0;
        load_valid_i = 1'b0;
        chk("collide_hi_ptr", 64'(dut.ptr_q), 64'd0);
        d0 = done_cnt;
        send_word(32'h55, 1'b0, 1);
        send_word(32'h77, 1'b1, 0);
        prog = '{32'h55, 32'h77};
        model_load(prog, 1'b1);
        finish_load(d0);
        read_line(10'd0, "collide_hi_line0", 64'h00000077_00000055);
        read_line(10'd1, "collide_hi_line1", {NOPW, 32'h00000003});

        // Reset after three accepted words.
        d0 = done_cnt;
        start_load();
        send_word(32'h71, 1'b0, 0);
        send_word(32'h72, 1'b0, 0);
        send_word(32'h73, 1'b0, 0);
        reset_i = 1'b1;
        step();
        chk("midreset_data", data_o, {NOPW, NOPW});
        chk("midreset_valid", 64'(data_valid_o), 64'd0);
        step();
        reset_i = 1'b0;
        chk("midreset_ptr", 64'(dut.ptr_q), 64'd0);
        read_line(10'd0, "midreset_line0", 64'h00000072_00000071);
        read_line(10'd1, "midreset_line1", {NOPW, 32'h00000003});
        chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);
        prog = '{32'h71, 32'h72, 32'h73};
        model_load(prog, 1'b0);

        // Randomized loads, some preceded by an abandoned partial load.
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(40, 1);
            prog = {};
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            d0 = done_cnt;
            if ($urandom_range(3, 0) == 0) begin
                k = $urandom_range(12, 1);
                part = {};
                for (int i = 0; i < k; i++) part.push_back($urandom);
                run_load(part, 1'b0, 2);
                model_load(part, 1'b0);
            end
            run_load(prog, 1'b1, 2);
            model_load(prog, 1'b1);
            finish_load(d0);
            read_known(8);
        end

        // Full-depth load without last wraps and completes on its own.
        prog = {};
        for (int i = 0; i < 2048; i++) prog.push_back(32'hC0000000 | 32'(i));
        d0 = done_cnt;
        run_load(prog, 1'b0, 0);
        model_load(prog, 1'b1);
        finish_load(d0);
        chk("wrap_ptr", 64'(dut.ptr_q), 64'd0);
        read_line(10'd1023, "wrap_line1023", 64'hC00007FF_C00007FE);
        read_line(10'd0, "wrap_line0", 64'hC0000001_C0000000);
        read_known(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
